ifu_fetch_ctrl: RTL and testbench

//  Parametrised next-generation fetch front end. Owns the PC, issues one

---
 rtl/ifu_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifu_fetch_ctrl
//
// Instruction fetch front end. Owns the program counter, issues one fetch at
// a time on a valid/ready request channel, captures the response into a
// one-entry instruction buffer and presents it downstream together with the
// PC it was fetched from. A redirect (branch or exception) loads a new PC and
// squashes whatever fetch is in flight.
//
// Parameters
//   XLEN    PC / address width
//   ILEN    instruction (response data) width
//   STEP    PC increment per fetch in bytes (power of two)
//   RST_PC  PC loaded on reset (low XLEN bits used)
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   redirect_valid/_pc        load a new PC and squash the current fetch
//   imem_req_valid/_ready     fetch request handshake
//   imem_req_addr             fetch address, always the current PC
//   imem_rsp_valid/_data      fetch response, always accepted
//   inst_valid/_ready         downstream instruction handshake
//   inst, inst_pc             buffered instruction and its PC
// ---------------------------------------------------------------------------
module ifu_fetch_ctrl #(
  parameter int          XLEN   = 64,
  parameter int          ILEN   = 32,
  parameter int          STEP   = 4,
  parameter logic [63:0] RST_PC = 64'h80000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(STEP - 1);
  localparam logic [XLEN-1:0] RST_PC_X   = RST_PC[XLEN-1:0];

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;

  // A redirect suppresses the request in the same cycle so the stale PC is
  // never sent to memory.
  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RST_PC_X;
      req_pc_q  <= '0;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    // Redirect wins over everything else; the per-state handling below only
    // decides what happens to the fetch that was in progress.
    if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end

    case (state_q)
      S_REQ: begin
        if (!redirect_valid && imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + STEP_X;
          state_d  = S_WAIT;
        end
      end

      // The memory still owes a response after a redirect, so remember to
      // throw it away rather than abandoning the wait.
      S_WAIT: begin
        if (redirect_valid) begin
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = req_pc_q;
            state_d   = S_HOLD;
          end
        end
      end

      // A redirect invalidates the buffer even if downstream is consuming it
      // this cycle, since that instruction is on the wrong path.
      S_HOLD: begin
        if (redirect_valid || inst_ready) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch_ctrl
//
// Directed bench for ifu_fetch_ctrl. One instance uses the default 64-bit
// configuration for the fetch, stall and redirect scenarios; a second 32-bit
// instance covers PC wrap-around and reset in the middle of a fetch.
// ---------------------------------------------------------------------------
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirValid = 1'b0;
  logic [63:0] redirPc = '0;
  logic        reqValid;
  logic        reqReady = 1'b0;
  logic [63:0] reqAddr;
  logic        rspValid = 1'b0;
  logic [31:0] rspData = '0;
  logic        instValid;
  logic        instReady = 1'b0;
  logic [31:0] instData;
  logic [63:0] instPc;

  logic        rst32 = 1'b1;
  logic        redirValid32 = 1'b0;
  logic [31:0] redirPc32 = '0;
  logic        reqValid32;
  logic        reqReady32 = 1'b0;
  logic [31:0] reqAddr32;
  logic        rspValid32 = 1'b0;
  logic [31:0] rspData32 = '0;
  logic        instValid32;
  logic        instReady32 = 1'b0;
  logic [31:0] instData32;
  logic [31:0] instPc32;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirValid),
    .redirect_pc    (redirPc),
    .imem_req_valid (reqValid),
    .imem_req_ready (reqReady),
    .imem_req_addr  (reqAddr),
    .imem_rsp_valid (rspValid),
    .imem_rsp_data  (rspData),
    .inst_valid     (instValid),
    .inst_ready     (instReady),
    .inst           (instData),
    .inst_pc        (instPc)
  );

  ifu_fetch_ctrl #(.XLEN(32)) dut32 (
    .clk            (clk),
    .rst            (rst32),
    .redirect_valid (redirValid32),
    .redirect_pc    (redirPc32),
    .imem_req_valid (reqValid32),
    .imem_req_ready (reqReady32),
    .imem_req_addr  (reqAddr32),
    .imem_rsp_valid (rspValid32),
    .imem_rsp_data  (rspData32),
    .inst_valid     (instValid32),
    .inst_ready     (instReady32),
    .inst           (instData32),
    .inst_pc        (instPc32)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs of the 64-bit instance, then let combinational outputs settle.
  task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic qr,
                               input logic sv, input logic [31:0] sd, input logic ir);
    redirValid = rv;
    redirPc    = rpc;
    reqReady   = qr;
    rspValid   = sv;
    rspData    = sd;
    instReady  = ir;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset values while reset is held.
    tick();
    checkOutput("rst_inst_valid", 64'(instValid), 64'h0);
    checkOutput("rst_addr", reqAddr, 64'h80000000);
    checkOutput("rst_inst_pc", instPc, 64'h0);
    checkOutput("rst_inst", 64'(instData), 64'h0);
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("post_rst_req_valid", 64'(reqValid), 64'h1);

    // Back-to-back fetches with a 1-cycle response and immediate consumption.
    for (int i = 0; i < 3; i++) begin
      logic [63:0] expPc;
      logic [31:0] expData;
      expPc   = 64'h80000000 + 64'(4 * i);
      expData = 32'hC0DE0000 + 32'(i);
      checkOutput("seq_req_addr", reqAddr, expPc);
      checkOutput("seq_req_valid", 64'(reqValid), 64'h1);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b1, expData, 1'b0);
      checkOutput("seq_wait_req_valid", 64'(reqValid), 64'h0);
      checkOutput("seq_wait_inst_valid", 64'(instValid), 64'h0);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
      checkOutput("seq_inst_valid", 64'(instValid), 64'h1);
      checkOutput("seq_inst", 64'(instData), 64'(expData));
      checkOutput("seq_inst_pc", instPc, expPc);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    end

    // Mid-operation reset returns everything to reset values immediately.
    rst = 1'b1;
    #1;
    checkOutput("midrst_addr", reqAddr, 64'h80000000);
    checkOutput("midrst_inst_pc", instPc, 64'h0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    rst = 1'b0;
    #1;

    // Request held off by the memory: address stays put.
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_addr", reqAddr, 64'h80000000);
      checkOutput("stall_req_valid", 64'(reqValid), 64'h1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0);
    checkOutput("stall_accept_pc", reqAddr, 64'h80000004);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    // Downstream back-pressure: buffer stable, no new request.
    for (int k = 0; k < 4; k++) begin
      checkOutput("hold_inst_valid", 64'(instValid), 64'h1);
      checkOutput("hold_inst", 64'(instData), 64'hAAAA0001);
      checkOutput("hold_inst_pc", instPc, 64'h80000000);
      checkOutput("hold_req_valid", 64'(reqValid), 64'h0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("release_req_valid", 64'(reqValid), 64'h1);
    checkOutput("release_addr", reqAddr, 64'h80000004);
    checkOutput("release_inst_valid", 64'(instValid), 64'h0);

    // Redirect while waiting; the late response must be dropped.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'h80001002, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("redir_wait_req_valid", 64'(reqValid), 64'h0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("redir_wait_addr", reqAddr, 64'h80001000);
    checkOutput("redir_wait_req_valid2", 64'(reqValid), 64'h0);
    tick();
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hDEAD0003, 1'b0);
    checkOutput("redir_wait_inst_valid", 64'(instValid), 64'h0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("drop_inst_valid", 64'(instValid), 64'h0);
    checkOutput("drop_req_valid", 64'(reqValid), 64'h1);
    checkOutput("drop_addr", reqAddr, 64'h80001000);

    // Redirect in the same cycle as the response.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'h80002007, 1'b0, 1'b1, 32'hBAD00004, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("redir_rsp_inst_valid", 64'(instValid), 64'h0);
    checkOutput("redir_rsp_req_valid", 64'(reqValid), 64'h1);
    checkOutput("redir_rsp_addr", reqAddr, 64'h80002004);

    // Redirect while holding, with downstream ready in the same cycle.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hBEEF0005, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("redir_hold_pre_valid", 64'(instValid), 64'h1);
    checkOutput("redir_hold_pre_pc", instPc, 64'h80002004);
    applyStimulus(1'b1, 64'h80003003, 1'b0, 1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("redir_hold_inst_valid", 64'(instValid), 64'h0);
    checkOutput("redir_hold_req_valid", 64'(reqValid), 64'h1);
    checkOutput("redir_hold_addr", reqAddr, 64'h80003000);

    // Redirect in the request state suppresses the request.
    applyStimulus(1'b1, 64'h80004000, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("redir_req_valid", 64'(reqValid), 64'h0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("redir_req_valid_after", 64'(reqValid), 64'h1);
    checkOutput("redir_req_addr", reqAddr, 64'h80004000);

    // Second redirect while a drop is pending keeps the drop.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'h80005000, 1'b0, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'h80006000, 1'b0, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hCAFE0006, 1'b0);
    checkOutput("dbl_redir_addr", reqAddr, 64'h80006000);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("dbl_redir_inst_valid", 64'(instValid), 64'h0);
    checkOutput("dbl_redir_req_valid", 64'(reqValid), 64'h1);

    // Stray response outside the wait state is ignored.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h12345678, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("stray_inst_valid", 64'(instValid), 64'h0);
    checkOutput("stray_addr", reqAddr, 64'h80006000);

    // Normal fetch afterwards proves the drop flag was cleared.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h0F0F0007, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("resume_inst_valid", 64'(instValid), 64'h1);
    checkOutput("resume_inst", 64'(instData), 64'h0F0F0007);
    checkOutput("resume_inst_pc", instPc, 64'h80006000);

    // 32-bit instance: PC wrap-around and reset during a fetch.
    tick();
    rst32        = 1'b0;
    redirValid32 = 1'b1;
    redirPc32    = 32'hFFFFFFFE;
    #1;
    checkOutput("w32_redir_req_valid", 64'(reqValid32), 64'h0);
    tick();
    redirValid32 = 1'b0;
    reqReady32   = 1'b1;
    #1;
    checkOutput("w32_addr_top", 64'(reqAddr32), 64'hFFFFFFFC);
    checkOutput("w32_req_valid", 64'(reqValid32), 64'h1);
    tick();
    reqReady32 = 1'b0;
    rspValid32 = 1'b1;
    rspData32  = 32'h13579BDF;
    #1;
    checkOutput("w32_wrap_addr", 64'(reqAddr32), 64'h0);
    tick();
    rspValid32 = 1'b0;
    #1;
    checkOutput("w32_inst_valid", 64'(instValid32), 64'h1);
    checkOutput("w32_inst_pc", 64'(instPc32), 64'hFFFFFFFC);
    checkOutput("w32_inst", 64'(instData32), 64'h13579BDF);
    instReady32 = 1'b1;
    tick();
    instReady32 = 1'b0;
    reqReady32  = 1'b1;
    #1;
    checkOutput("w32_next_addr", 64'(reqAddr32), 64'h0);
    tick();
    reqReady32 = 1'b0;
    #1;
    checkOutput("w32_wait_addr", 64'(reqAddr32), 64'h4);
    rst32 = 1'b1;
    #1;
    checkOutput("w32_rst_addr", 64'(reqAddr32), 64'h80000000);
    checkOutput("w32_rst_inst_valid", 64'(instValid32), 64'h0);
    checkOutput("w32_rst_inst_pc", 64'(instPc32), 64'h0);
    tick();
    rst32      = 1'b0;
    rspValid32 = 1'b1;
    rspData32  = 32'h5A5A5A5A;
    #1;
    tick();
    rspValid32 = 1'b0;
    #1;
    checkOutput("w32_late_rsp_inst_valid", 64'(instValid32), 64'h0);
    checkOutput("w32_late_rsp_req_valid", 64'(reqValid32), 64'h1);
    checkOutput("w32_late_rsp_addr", 64'(reqAddr32), 64'h80000000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
